// File: rtl/dmem_pkg.sv
// Shared constants and types for the data-memory arbiter: RAM depth, MMIO map,
// requester indices and the per-cycle port selection.
package dmem_pkg;

  localparam int unsigned RAM_WORDS_DEF  = 512;
  localparam logic [3:0]  MAX_WAIT_DEF   = 4'd8;

  localparam logic [31:0] MMIO_LED_ADDR  = 32'h4000_000C;
  localparam logic [31:0] MMIO_DISP_ADDR = 32'h4000_0010;

  localparam int REQ_CPU = 0;
  localparam int REQ_DMA = 1;

  typedef enum logic [1:0] {
    SEL_IDLE,
    SEL_CPU,
    SEL_DMA
  } sel_e;

  function automatic logic in_ram(input logic [31:0] addr, input int unsigned words);
    return ({2'b00, addr[31:2]} < words);
  endfunction

endpackage

// File: rtl/dmem_arb_wait_ctr.sv
// Saturating count of consecutive loader denials; raises o_force once the
// loader has waited MAX_WAIT cycles.
module dmem_arb_wait_ctr
  import dmem_pkg::*;
#(
  parameter logic [3:0] MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic i_dma_req,
  input  logic i_dma_gnt,
  output logic o_force
);

  logic [3:0] r_wait_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wait_cnt <= '0;
    end else if (i_dma_req && !i_dma_gnt) begin
      if (r_wait_cnt != MAX_WAIT) begin
        r_wait_cnt <= r_wait_cnt + 4'd1;
      end
    end else begin
      r_wait_cnt <= '0;
    end
  end

  assign o_force = (r_wait_cnt == MAX_WAIT);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter (CPU MEM stage, loader/DMA) for the single-port data
// memory. Optional bounded-wait guard: define DMEM_ARB_STARVE_GUARD_EN.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned RAM_WORDS = RAM_WORDS_DEF,
  parameter logic [3:0]  MAX_WAIT  = MAX_WAIT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_gnt,
  output logic        cpu_stall,
  output logic        cpu_rvalid,
  output logic [31:0] cpu_rdata,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic        dma_gnt,
  output logic        dma_rvalid,
  output logic [31:0] dma_rdata,
  output logic        dma_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_write,
  output logic        mem_read,
  input  logic [31:0] mem_rdata
);

  sel_e        w_sel;
  logic [1:0]  w_gnt;
  logic        w_force;
  logic        w_dma_oor;

  logic        r_cpu_rvalid;
  logic [31:0] r_cpu_rdata;
  logic        r_dma_rvalid;
  logic [31:0] r_dma_rdata;
  logic        r_dma_err;

`ifdef DMEM_ARB_STARVE_GUARD_EN
  dmem_arb_wait_ctr #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_ctr (
    .clk       (clk),
    .reset     (reset),
    .i_dma_req (dma_req),
    .i_dma_gnt (dma_gnt),
    .o_force   (w_force)
  );
`else
  logic w_unused_max_wait;
  assign w_unused_max_wait = ^MAX_WAIT;
  assign w_force           = 1'b0;
`endif

  assign w_dma_oor = !in_ram(dma_addr, RAM_WORDS);

  // force only matters while the loader is still asking; a saturated count
  // left over from an abandoned request must not block a lone CPU access.
  always_comb begin
    w_sel = SEL_IDLE;
    if (dma_req && (!cpu_req || w_force)) begin
      w_sel = SEL_DMA;
    end else if (cpu_req) begin
      w_sel = SEL_CPU;
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_write = 1'b0;
    mem_read  = 1'b0;
    case (w_sel)
      SEL_CPU: begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_write = cpu_we;
        mem_read  = !cpu_we;
      end
      SEL_DMA: begin
        mem_addr  = dma_addr;
        mem_wdata = dma_wdata;
        mem_write = dma_we && !w_dma_oor;
        mem_read  = !dma_we && !w_dma_oor;
      end
      default: ;
    endcase
  end

  assign w_gnt[REQ_CPU] = (w_sel == SEL_CPU);
  assign w_gnt[REQ_DMA] = (w_sel == SEL_DMA);
  assign cpu_gnt        = w_gnt[REQ_CPU];
  assign dma_gnt        = w_gnt[REQ_DMA];
  assign cpu_stall      = cpu_req && !cpu_gnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cpu_rvalid <= 1'b0;
      r_cpu_rdata  <= '0;
      r_dma_rvalid <= 1'b0;
      r_dma_rdata  <= '0;
      r_dma_err    <= 1'b0;
    end else begin
      r_cpu_rvalid <= cpu_gnt && !cpu_we;
      if (cpu_gnt && !cpu_we) begin
        r_cpu_rdata <= mem_rdata;
      end
      r_dma_rvalid <= dma_gnt && !dma_we;
      if (dma_gnt && !dma_we) begin
        r_dma_rdata <= w_dma_oor ? '0 : mem_rdata;
      end
      r_dma_err <= dma_gnt && w_dma_oor;
    end
  end

  assign cpu_rvalid = r_cpu_rvalid;
  assign cpu_rdata  = r_cpu_rdata;
  assign dma_rvalid = r_dma_rvalid;
  assign dma_rdata  = r_dma_rdata;
  assign dma_err    = r_dma_err;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table, starvation and reset
// sequences, then constrained-random traffic against a reference model.
module tb_dmem_arbiter;

  localparam int unsigned RAMW = 512;
  localparam int          MAXW = 8;
`ifdef DMEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata, mem_rdata;
  logic        cpu_gnt, cpu_stall, cpu_rvalid, dma_gnt, dma_rvalid, dma_err;
  logic        mem_write, mem_read;
  logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(
    .RAM_WORDS (RAMW),
    .MAX_WAIT  (4'(MAXW))
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_stall  (cpu_stall),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .dma_req    (dma_req),
    .dma_we     (dma_we),
    .dma_addr   (dma_addr),
    .dma_wdata  (dma_wdata),
    .dma_gnt    (dma_gnt),
    .dma_rvalid (dma_rvalid),
    .dma_rdata  (dma_rdata),
    .dma_err    (dma_err),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_write  (mem_write),
    .mem_read   (mem_read),
    .mem_rdata  (mem_rdata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
    mem_rdata = '0;
  endtask

  typedef struct {
    logic        cr, cw;
    logic [31:0] ca, cd;
    logic        dr, dw;
    logic [31:0] da, dd, rd;
    logic        e_cg, e_dg, e_mw, e_mr;
    logic [31:0] e_addr, e_wd;
    logic        e_crv;
    logic [31:0] e_crd;
    logic        e_drv;
    logic [31:0] e_drd;
    logic        e_err;
  } vec_t;

  vec_t tbl[11];

  // reference model state
  int          m_denied;
  logic        m_crv, m_drv, m_err;
  logic [31:0] m_crd, m_drd;

  initial begin
    int first_gnt, n_stall, stall_cyc;
    logic g;

    tbl[0]  = '{1, 0, 32'h10, 0,        0, 0, 0, 0,            117,     1, 0, 0, 1, 32'h10, 0,        0, 0,   0, 0,     0};
    tbl[1]  = '{1, 1, 32'h4000000C, 32'h5A, 1, 0, 0, 0,        0,       1, 0, 1, 0, 32'h4000000C, 32'h5A, 1, 117, 0, 0,   0};
    tbl[2]  = '{0, 0, 0, 0,             1, 0, 0, 0,            32'h33,  0, 1, 0, 1, 0, 0,             0, 117, 0, 0,     0};
    tbl[3]  = '{0, 0, 0, 0,             0, 0, 0, 0,            0,       0, 0, 0, 0, 0, 0,             0, 117, 1, 32'h33, 0};
    tbl[4]  = '{0, 0, 0, 0,             1, 0, 32'h40000010, 0, 32'hDEAD, 0, 1, 0, 0, 32'h40000010, 0, 0, 117, 0, 32'h33, 0};
    tbl[5]  = '{1, 0, 0, 0,             0, 0, 0, 0,            108,     1, 0, 0, 1, 0, 0,             0, 117, 1, 0,     1};
    tbl[6]  = '{1, 0, 4, 0,             0, 0, 0, 0,            105,     1, 0, 0, 1, 4, 0,             1, 108, 0, 0,     0};
    tbl[7]  = '{0, 0, 0, 0,             0, 0, 0, 0,            0,       0, 0, 0, 0, 0, 0,             1, 105, 0, 0,     0};
    tbl[8]  = '{0, 0, 0, 0,             1, 1, 32'h7FC, 1,      0,       0, 1, 1, 0, 32'h7FC, 1,       0, 105, 0, 0,     0};
    tbl[9]  = '{0, 0, 0, 0,             1, 1, 32'h800, 2,      0,       0, 1, 0, 0, 32'h800, 2,       0, 105, 0, 0,     0};
    tbl[10] = '{0, 0, 0, 0,             0, 0, 0, 0,            0,       0, 0, 0, 0, 0, 0,             0, 105, 0, 0,     1};

    // reset state
    reset = 1'b1;
    idle_inputs();
    @(negedge clk);
    chk("rst cpu_rvalid", 32'(cpu_rvalid), 0);
    chk("rst cpu_rdata", cpu_rdata, 0);
    chk("rst dma_rvalid", 32'(dma_rvalid), 0);
    chk("rst dma_rdata", dma_rdata, 0);
    chk("rst dma_err", 32'(dma_err), 0);
    chk("rst mem_rw", {30'b0, mem_write, mem_read}, 0);
    chk("rst mem_addr", mem_addr, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // directed vectors, one per cycle
    for (int i = 0; i < 11; i++) begin
      cpu_req = tbl[i].cr; cpu_we = tbl[i].cw; cpu_addr = tbl[i].ca; cpu_wdata = tbl[i].cd;
      dma_req = tbl[i].dr; dma_we = tbl[i].dw; dma_addr = tbl[i].da; dma_wdata = tbl[i].dd;
      mem_rdata = tbl[i].rd;
      @(negedge clk);
      chk($sformatf("v%0d cpu_gnt", i), 32'(cpu_gnt), 32'(tbl[i].e_cg));
      chk($sformatf("v%0d cpu_stall", i), 32'(cpu_stall), 32'(tbl[i].cr & ~tbl[i].e_cg));
      chk($sformatf("v%0d dma_gnt", i), 32'(dma_gnt), 32'(tbl[i].e_dg));
      chk($sformatf("v%0d mem_write", i), 32'(mem_write), 32'(tbl[i].e_mw));
      chk($sformatf("v%0d mem_read", i), 32'(mem_read), 32'(tbl[i].e_mr));
      chk($sformatf("v%0d mem_addr", i), mem_addr, tbl[i].e_addr);
      chk($sformatf("v%0d mem_wdata", i), mem_wdata, tbl[i].e_wd);
      chk($sformatf("v%0d cpu_rvalid", i), 32'(cpu_rvalid), 32'(tbl[i].e_crv));
      chk($sformatf("v%0d cpu_rdata", i), cpu_rdata, tbl[i].e_crd);
      chk($sformatf("v%0d dma_rvalid", i), 32'(dma_rvalid), 32'(tbl[i].e_drv));
      chk($sformatf("v%0d dma_rdata", i), dma_rdata, tbl[i].e_drd);
      chk($sformatf("v%0d dma_err", i), 32'(dma_err), 32'(tbl[i].e_err));
      @(posedge clk); #1;
    end

    // starvation: CPU reads every cycle, loader read held until granted
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h20;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h8; mem_rdata = 32'd5;
    first_gnt = -1; n_stall = 0; stall_cyc = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      g = dma_gnt;
      if (g && first_gnt < 0) first_gnt = c;
      if (cpu_stall) begin
        n_stall++;
        stall_cyc = c;
      end
      @(posedge clk); #1;
      if (g) dma_req = 1'b0;
    end
    chk("starve first dma_gnt", 32'(first_gnt), GUARD ? 32'(MAXW) : 32'hFFFF_FFFF);
    chk("starve stall count", 32'(n_stall), GUARD ? 1 : 0);
    chk("starve stall cycle", 32'(stall_cyc), GUARD ? 32'(MAXW) : 32'hFFFF_FFFF);

    // reset lands during a read grant: the pending response is dropped
    idle_inputs();
    cpu_req = 1'b1; cpu_addr = 32'h30; mem_rdata = 32'd77;
    @(negedge clk);
    chk("rstmid cpu_gnt", 32'(cpu_gnt), 1);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    chk("rstmid cpu_rvalid", 32'(cpu_rvalid), 0);
    chk("rstmid cpu_rdata", cpu_rdata, 0);
    idle_inputs();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("post-rst cpu_rvalid", 32'(cpu_rvalid), 0);
      chk("post-rst dma_err", 32'(dma_err), 0);
      @(posedge clk); #1;
    end

    // random traffic against the reference model, starting from reset
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    m_denied = 0; m_crv = 0; m_drv = 0; m_err = 0; m_crd = '0; m_drd = '0;
    for (int c = 0; c < 400; c++) begin
      logic        frc, e_dg, e_cg, oor, e_mw, e_mr;
      logic [31:0] e_addr, e_wd;
      int unsigned r;
      mem_rdata = $urandom;
      @(negedge clk);
      frc  = GUARD && dma_req && (m_denied >= MAXW);
      e_dg = dma_req && (!cpu_req || frc);
      e_cg = cpu_req && !e_dg;
      oor  = (dma_addr / 4) >= RAMW;
      e_addr = '0; e_wd = '0; e_mw = 0; e_mr = 0;
      if (e_cg) begin
        e_addr = cpu_addr; e_wd = cpu_wdata; e_mw = cpu_we; e_mr = !cpu_we;
      end else if (e_dg) begin
        e_addr = dma_addr; e_wd = dma_wdata; e_mw = dma_we && !oor; e_mr = !dma_we && !oor;
      end
      chk("rnd cpu_gnt", 32'(cpu_gnt), 32'(e_cg));
      chk("rnd dma_gnt", 32'(dma_gnt), 32'(e_dg));
      chk("rnd cpu_stall", 32'(cpu_stall), 32'(cpu_req && !e_cg));
      chk("rnd mem_write", 32'(mem_write), 32'(e_mw));
      chk("rnd mem_read", 32'(mem_read), 32'(e_mr));
      chk("rnd mem_addr", mem_addr, e_addr);
      chk("rnd mem_wdata", mem_wdata, e_wd);
      chk("rnd cpu_rvalid", 32'(cpu_rvalid), 32'(m_crv));
      chk("rnd cpu_rdata", cpu_rdata, m_crd);
      chk("rnd dma_rvalid", 32'(dma_rvalid), 32'(m_drv));
      chk("rnd dma_rdata", dma_rdata, m_drd);
      chk("rnd dma_err", 32'(dma_err), 32'(m_err));
      m_crv = e_cg && !cpu_we;
      if (m_crv) m_crd = mem_rdata;
      m_drv = e_dg && !dma_we;
      if (m_drv) m_drd = oor ? 32'h0 : mem_rdata;
      m_err = e_dg && oor;
      m_denied = (dma_req && !e_dg) ? ((m_denied + 1 > MAXW) ? MAXW : m_denied + 1) : 0;
      @(posedge clk); #1;
      if (!(cpu_req && !e_cg)) begin
        cpu_req   = ($urandom % 10) < 7;
        cpu_we    = $urandom % 2;
        cpu_addr  = $urandom;
        cpu_wdata = $urandom;
      end
      if (dma_req && !e_dg) begin
        if ($urandom % 16 == 0) dma_req = 1'b0;
      end else begin
        dma_req   = ($urandom % 10) < 5;
        dma_we    = $urandom % 2;
        dma_wdata = $urandom;
        r = $urandom % 8;
        case (r)
          0:       dma_addr = 32'h4000_0010;
          1:       dma_addr = 32'h4000_000C;
          2:       dma_addr = (RAMW - 1) * 4;
          3:       dma_addr = RAMW * 4;
          default: dma_addr = ($urandom % RAMW) * 4;
        endcase
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
